// File: rtl/ctrl_pkg.sv
// ctrl_pkg: items shared by the I2S APB feeder and its APB sequencer.
//   OP_t           - transceiver control word written once per enable edge
//   feeder_state_t - feeder FSM states
//   FLG_*          - bit positions inside the transceiver status flags
package ctrl_pkg;

    typedef logic [14:0] OP_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CFG_S  = 4'd1,
        S_CFG_A  = 4'd2,
        S_POLL_S = 4'd3,
        S_POLL_A = 4'd4,
        S_DECIDE = 4'd5,
        S_WR_S   = 4'd6,
        S_WR_A   = 4'd7,
        S_GAP    = 4'd8
    } feeder_state_t;

    localparam int FLG_IDLE    = 9;
    localparam int FLG_TXFULL  = 7;
    localparam int FLG_TXEMPTY = 6;
    localparam int FLG_TXAFULL = 5;

endpackage

// File: rtl/apb_xfer.sv
// apb_xfer: two-cycle APB master sequencer (SETUP then ACCESS, no wait states).
//   pclk, preset      clock, async active-high reset
//   i_start           pulse in the cycle before SETUP; loads addr/wr/wdata
//   i_wr, i_addr      transfer direction and byte address
//   i_wdata           write data (loaded only for writes)
//   i_prdata          read data from the slave, sampled at the end of ACCESS
//   o_psel..o_pwdata  registered APB master outputs
//   o_done            high during the ACCESS cycle
//   o_rdata           last read data, held until the next read completes
module apb_xfer #(
    parameter int RDW = 10
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic            i_start,
    input  logic            i_wr,
    input  logic [31:0]     i_addr,
    input  logic [31:0]     i_wdata,
    input  logic [RDW-1:0]  i_prdata,
    output logic            o_psel,
    output logic            o_penable,
    output logic            o_pwrite,
    output logic [31:0]     o_paddr,
    output logic [31:0]     o_pwdata,
    output logic            o_done,
    output logic [RDW-1:0]  o_rdata
);

    logic           r_psel, r_penable, r_pwrite;
    logic [31:0]    r_paddr, r_pwdata;
    logic [RDW-1:0] r_rdata;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
        end else begin
            // start has priority so an ACCESS cycle can chain straight into
            // the next SETUP without an idle cycle in between
            if (i_start) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_paddr   <= i_addr;
                r_pwrite  <= i_wr;
                if (i_wr) r_pwdata <= i_wdata;
            end else if (r_psel && !r_penable) begin
                r_penable <= 1'b1;
            end else begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
            if (r_psel && r_penable && !r_pwrite) r_rdata <= i_prdata;
        end
    end

    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_done    = r_psel & r_penable;
    assign o_rdata   = r_rdata;

endmodule

// File: rtl/i2s_apb_feeder.sv
// i2s_apb_feeder: APB master that configures the I2S transceiver once per
// enable edge, then polls its status flags and writes bursts of PCM samples
// into the Tx data register while the Tx FIFO has room.
//   pclk, preset          clock, async active-high reset
//   en                    level enable (rising edge starts a session)
//   ctrl_word             control word written to CTRL_ADDR
//   s_valid/s_data/s_ready upstream sample stream (s_ready = accept strobe)
//   psel..pwdata, prdata  APB master bus
//   words_sent            wrapping count of completed Tx writes
//   underruns             saturating count of observed Tx underruns
//   busy                  high whenever the FSM is not IDLE
module i2s_apb_feeder
    import ctrl_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR = 32'h0,
    parameter logic [31:0] STAT_ADDR = 32'h4,
    parameter logic [31:0] TX_ADDR   = 32'h8,
    parameter int          BURST     = 4,
    parameter int          POLL_GAP  = 8
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        en,
    input  OP_t         ctrl_word,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic [15:0] words_sent,
    output logic [7:0]  underruns,
    output logic        busy
);

    localparam logic [3:0] BURST_L  = 4'(BURST);
    // GAP lasts POLL_GAP cycles, but never less than one
    localparam logic [7:0] GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    feeder_state_t r_state, w_nxt;
    logic          r_en_d, r_rise;
    logic [3:0]    r_burst;
    logic [7:0]    r_gap;
    logic [15:0]   r_words;
    logic [7:0]    r_urun;
    logic          r_s_ready, r_busy;

    logic          w_start, w_wr, w_done;
    logic [31:0]   w_addr, w_wdata;
    logic [9:0]    w_stat;
    logic          w_underrun;
    logic          w_unused;

    assign w_unused = &{1'b0, prdata[31:10]};

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_rise) w_nxt = S_CFG_S;
            S_CFG_S:  w_nxt = S_CFG_A;
            S_CFG_A:  if (w_done) w_nxt = en ? S_POLL_S : S_IDLE;
            S_POLL_S: w_nxt = S_POLL_A;
            S_POLL_A: if (w_done) w_nxt = en ? S_DECIDE : S_IDLE;
            S_DECIDE: begin
                if (!en)                                         w_nxt = S_IDLE;
                else if (w_stat[FLG_TXFULL] || w_stat[FLG_TXAFULL]) w_nxt = S_GAP;
                else if (s_valid)                                w_nxt = S_WR_S;
                else                                             w_nxt = S_POLL_S;
            end
            S_WR_S:   w_nxt = S_WR_A;
            S_WR_A: begin
                if (w_done) begin
                    if (!en)                              w_nxt = S_IDLE;
                    else if (r_burst < BURST_L && s_valid) w_nxt = S_WR_S;
                    else                                  w_nxt = S_POLL_S;
                end
            end
            S_GAP: begin
                if (!en)                    w_nxt = S_IDLE;
                else if (r_gap == GAP_LAST) w_nxt = S_POLL_S;
            end
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Every SETUP state is entered from a non-SETUP state, so entering one
    // is exactly the sequencer start pulse.
    always_comb begin
        w_start = (w_nxt == S_CFG_S) || (w_nxt == S_POLL_S) || (w_nxt == S_WR_S);
        w_wr    = (w_nxt != S_POLL_S);
        case (w_nxt)
            S_CFG_S:  w_addr = CTRL_ADDR;
            S_POLL_S: w_addr = STAT_ADDR;
            default:  w_addr = TX_ADDR;
        endcase
        w_wdata = (w_nxt == S_CFG_S) ? {17'b0, ctrl_word} : s_data;
    end

    assign w_underrun = w_stat[FLG_TXEMPTY] && !w_stat[FLG_IDLE] && (r_words != 16'd0);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_rise    <= 1'b0;
            r_burst   <= '0;
            r_gap     <= '0;
            r_words   <= '0;
            r_urun    <= '0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // edge is registered once more so IDLE leaves two cycles after en rises
            r_en_d    <= en;
            r_rise    <= en & ~r_en_d;
            r_state   <= w_nxt;
            r_s_ready <= (w_nxt == S_WR_S);
            r_busy    <= (w_nxt != S_IDLE);
            if (r_state == S_DECIDE && w_nxt == S_WR_S)    r_burst <= 4'd1;
            else if (r_state == S_WR_A && w_nxt == S_WR_S) r_burst <= r_burst + 4'd1;
            r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
            if (r_state == S_WR_A && w_done) r_words <= r_words + 16'd1;
            if (r_state == S_DECIDE && en && w_underrun && r_urun != 8'hFF)
                r_urun <= r_urun + 8'd1;
        end
    end

    apb_xfer #(.RDW(10)) u_xfer (
        .pclk      (pclk),
        .preset    (preset),
        .i_start   (w_start),
        .i_wr      (w_wr),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_prdata  (prdata[9:0]),
        .o_psel    (psel),
        .o_penable (penable),
        .o_pwrite  (pwrite),
        .o_paddr   (paddr),
        .o_pwdata  (pwdata),
        .o_done    (w_done),
        .o_rdata   (w_stat)
    );

    assign s_ready    = r_s_ready;
    assign words_sent = r_words;
    assign underruns  = r_urun;
    assign busy       = r_busy;

endmodule
